// File: rtl/eop_filter.sv
// Clocked USB end-of-packet filter: qualifies SE0 runs followed by J and strobes eop / eop_err.
// Optional macro EOP_SE1_ERR_EN treats SE1 as a line error instead of decoding it as J.
module eop_filter #(
    parameter int SE0_MIN = 2,
    parameter int SE0_MAX = 3,
    parameter int J_MIN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    output logic se0,
    output logic eop_active,
    output logic eop,
    output logic eop_err
);

    localparam int CNT_W  = $clog2(SE0_MAX + 2);
    localparam int JCNT_W = (J_MIN > 1) ? $clog2(J_MIN + 1) : 1;

    localparam logic [CNT_W-1:0]  SE0_MIN_C = CNT_W'(SE0_MIN);
    localparam logic [CNT_W-1:0]  SE0_MAX_C = CNT_W'(SE0_MAX);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(SE0_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [JCNT_W-1:0] J_MIN_C   = JCNT_W'(J_MIN);
    localparam logic [JCNT_W-1:0] JCNT_ONE  = JCNT_W'(1);

    generate
        if (SE0_MIN < 1 || SE0_MAX < SE0_MIN || J_MIN < 1) begin : g_param_err
            $error("eop_filter: illegal parameters SE0_MIN=%0d SE0_MAX=%0d J_MIN=%0d",
                   SE0_MIN, SE0_MAX, J_MIN);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COUNT, J_WAIT, ABORT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [JCNT_W-1:0]  jcnt_reg, jcnt_next, jcnt_inc;
    logic               dp_reg, dm_reg;
    logic               eop_reg, eop_next;
    logic               err_reg, err_next;
    logic               is_se0, is_j, is_se1;

    assign is_se0 = ~dp_reg & ~dm_reg;
`ifdef EOP_SE1_ERR_EN
    assign is_j   = dp_reg & ~dm_reg;
    assign is_se1 = dp_reg & dm_reg;
`else
    // SE1 folds into J, so it can never produce an error.
    assign is_j   = dp_reg;
    assign is_se1 = 1'b0;
`endif

    assign cnt_inc  = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_ONE;
    assign jcnt_inc = jcnt_reg + JCNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_reg    <= 1'b1;
            dm_reg    <= 1'b0;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            jcnt_reg  <= '0;
            eop_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            dp_reg    <= d_plus;
            dm_reg    <= d_minus;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            jcnt_reg  <= jcnt_next;
            eop_reg   <= eop_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        jcnt_next  = jcnt_reg;
        eop_next   = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_se0) begin
                    state_next = COUNT;
                    cnt_next   = CNT_ONE;
                end else if (is_se1) begin
                    err_next = 1'b1;
                end
            end
            COUNT: begin
                if (is_se0) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc > SE0_MAX_C) begin
                        err_next   = 1'b1;
                        state_next = ABORT;
                    end
                end else if (is_se1) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg < SE0_MIN_C) begin
                    state_next = IDLE;
                end else if (is_j) begin
                    if (J_MIN == 1) begin
                        eop_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = J_WAIT;
                        jcnt_next  = JCNT_ONE;
                    end
                end else begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            J_WAIT: begin
                if (is_se0) begin
                    // Error on the old packet and start counting the new SE0 run at once.
                    err_next   = 1'b1;
                    state_next = COUNT;
                    cnt_next   = CNT_ONE;
                end else if (is_j) begin
                    jcnt_next = jcnt_inc;
                    if (jcnt_inc == J_MIN_C) begin
                        eop_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            ABORT: begin
                if (!is_se0) begin
                    err_next   = is_se1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == IDLE) begin
            cnt_next  = '0;
            jcnt_next = '0;
        end
    end

    assign se0        = is_se0;
    assign eop_active = ((state_reg == COUNT) && (cnt_reg >= SE0_MIN_C)) || (state_reg == J_WAIT);
    assign eop        = eop_reg;
    assign eop_err    = err_reg;

endmodule

// File: tb/tb_eop_filter.sv
// Directed bench for eop_filter: default instance plus a J_MIN=2 instance sharing the same line.
`timescale 1ns/1ps
module tb_eop_filter;

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] L0 = 2'b00;
    localparam logic [1:0] L1 = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_plus = 1'b1;
    logic d_minus = 1'b0;
    logic se0_a, eop_active_a, eop_a, eop_err_a;
    logic se0_b, eop_active_b, eop_b, eop_err_b;
    logic [3:0] obs, obs2;
    int n_cmp = 0;
    int n_bad = 0;

    eop_filter dut_a (
        .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus),
        .se0(se0_a), .eop_active(eop_active_a), .eop(eop_a), .eop_err(eop_err_a)
    );

    eop_filter #(.SE0_MIN(2), .SE0_MAX(3), .J_MIN(2)) dut_b (
        .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus),
        .se0(se0_b), .eop_active(eop_active_b), .eop(eop_b), .eop_err(eop_err_b)
    );

    always #5 clk = ~clk;

    // One line sample per cycle; outputs are observed on the following falling edge.
    task automatic cyc(input logic [1:0] l);
        @(posedge clk);
        #2;
        {d_plus, d_minus} = l;
        @(negedge clk);
        obs  = {se0_a, eop_active_a, eop_a, eop_err_a};
        obs2 = {se0_b, eop_active_b, eop_b, eop_err_b};
    endtask

    task automatic test_reset();
        logic [1:0] ln [12] = '{LJ, LJ, LJ, L0, LJ, LJ, LJ, L0, L0, LJ, LJ, LJ};
        logic [3:0] ex [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                                4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0010};
        rst = 1'b1;
        {d_plus, d_minus} = LJ;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({se0_a, eop_active_a, eop_a, eop_err_a} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_init: got %b want 0000", {se0_a, eop_active_a, eop_a, eop_err_a});
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(LJ);
        cyc(L0);
        cyc(L0);
        cyc(L0);
        n_cmp++;
        if (obs !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_prerun: got %b want 1000", obs);
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if (eop_active_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midrun_active: got %b want 1", eop_active_a);
        end
        rst = 1'b1;
        {d_plus, d_minus} = LJ;
        #1;
        n_cmp++;
        if ({se0_a, eop_active_a, eop_a, eop_err_a} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_async: got %b want 0000", {se0_a, eop_active_a, eop_a, eop_err_a});
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(ln[i]);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL reset_release step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_valid_eop();
        logic [1:0] ln [7] = '{LJ, L0, L0, LJ, LJ, LJ, LJ};
        logic [3:0] ex [7] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            cyc(ln[i]);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL valid_eop step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] ln [6] = '{LJ, L0, LJ, LJ, LJ, LJ};
        logic [3:0] ex [6] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            cyc(ln[i]);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL glitch step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_long_se0();
        logic [1:0] ln [14] = '{LJ, L0, L0, L0, L0, L0, LJ, LJ, LJ, L0, L0, LJ, LJ, LJ};
        logic [3:0] ex [14] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1001,
                                4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0010};
        for (int i = 0; i < 14; i++) begin
            cyc(ln[i]);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL long_se0 step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_bad_follow();
        logic [1:0] lk [7] = '{LJ, L0, L0, LK, LJ, LJ, LJ};
        logic [1:0] ls [7] = '{LJ, L0, L0, L1, LJ, LJ, LJ};
        logic [3:0] ex [7] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0001, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            cyc(lk[i]);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL se0_then_k step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
`ifndef EOP_SE1_ERR_EN
        ex[5] = 4'b0010;
`endif
        for (int i = 0; i < 7; i++) begin
            cyc(ls[i]);
            n_cmp++;
            if (obs !== ex[i]) begin
                n_bad++;
                $display("FAIL se0_then_se1 step %0d: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_jmin2();
        logic [1:0] ln [11] = '{LJ, L0, L0, LJ, L0, L0, LJ, LJ, LJ, LJ, LJ};
        logic [3:0] ex [11] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b1100,
                                4'b1001, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
        for (int i = 0; i < 11; i++) begin
            cyc(ln[i]);
            n_cmp++;
            if (obs2 !== ex[i]) begin
                n_bad++;
                $display("FAIL jmin2 step %0d: got %b want %b", i, obs2, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_eop();
        test_glitch();
        test_long_se0();
        test_bad_follow();
        test_jmin2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
